pi_digit_streamer: RTL and testbench

PI_DIGIT_STREAMER -- requirements
Module: pi_digit_streamer

---
 rtl/pi_pkg.sv | 24 ++
 rtl/limb_to_bcd.sv | 64 ++++++
 rtl/pi_digit_streamer.sv | 221 ++++++++++++++++++++++
 tb/tb_pi_digit_streamer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/pi_pkg.sv
// Shared types and constants for the pi digit streamer.
package pi_pkg;

  localparam int PI_WIDTH = 16;
  localparam int PI_L     = 4;

  // Multi-precision value, limb PI_L-1 most significant, each limb base 10000.
  typedef logic [PI_L-1:0][PI_WIDTH-1:0] limbs_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CONV  = 3'd1,
    ST_EMIT  = 3'd2,
    ST_POINT = 3'd3,
    ST_EOL   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_POINT = 8'h2E;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

endpackage

// File: rtl/limb_to_bcd.sv
// Binary to five-digit BCD converter (shift-and-add-3), one bit per cycle.
module limb_to_bcd #(
  parameter int WIDTH = 16
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             ready,
  output logic [19:0]      bcd
);

  localparam int SRW = 20 + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);

  logic [SRW-1:0] sr_r;
  logic [CW-1:0]  cnt_r;
  logic           ready_r;
  logic [SRW-1:0] adj_s;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
  function automatic logic [19:0] add3(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Corrected register image to be shifted on the next edge.
  always_comb begin
    adj_s = {add3(sr_r[SRW-1:WIDTH]), sr_r[WIDTH-1:0]};
  end

  // Shift register, bit counter and completion flag.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      sr_r    <= {SRW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      ready_r <= 1'b0;
    end else if (load) begin
      sr_r    <= {20'd0, value};
      cnt_r   <= CW'(WIDTH);
      ready_r <= 1'b0;
    end else if (cnt_r != {CW{1'b0}}) begin
      sr_r    <= {adj_s[SRW-2:0], 1'b0};
      cnt_r   <= cnt_r - CW'(1);
      ready_r <= (cnt_r == CW'(1));
    end else begin
      sr_r    <= sr_r;
      cnt_r   <= cnt_r;
      ready_r <= ready_r;
    end
  end

  assign ready = ready_r;
  assign bcd   = sr_r[SRW-1:WIDTH];

endmodule

// File: rtl/pi_digit_streamer.sv
// Streams a base-10000 multi-precision value as ASCII "III.FFFF...\n".
module pi_digit_streamer
  import pi_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int L          = 4,
  parameter int INT_DIGITS = 2,
  parameter int MAX        = 10000
) (
  input  logic                    ck,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [L-1:0][WIDTH-1:0] in,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [7:0]              out_char,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int IW = (L > 1) ? $clog2(L) : 1;
  localparam logic [IW-1:0] IDX_TOP  = IW'(L - 1);
  localparam logic [IW-1:0] LAST_INT = IW'(L - INT_DIGITS);
  localparam bit HAS_FRAC = (INT_DIGITS != L);

  state_e                  state_r, state_nx;
  logic [L-1:0][WIDTH-1:0] snap_r, snap_nx;
  logic [IW-1:0]           idx_r, idx_nx;
  logic [1:0]              dig_r, dig_nx;
  logic                    load_r, load_nx;
  logic                    seen_r, seen_nx;
  logic                    start_d_r, arm_r;
  logic                    out_valid_r, out_valid_nx;
  logic [7:0]              out_char_r, out_char_nx;
  logic                    busy_r, done_r, done_nx;
  logic                    error_r, error_nx;

  logic                    lb_ready_s;
  logic [19:0]             lb_bcd_s;
  logic                    trig_s, xfer_s, bad_s, int_limb_s, skip_s;
  logic [1:0]              pos_s;

  // Character for BCD digit p; an out-of-range limb shows as '?'.
  function automatic logic [7:0] digit_char(input logic [19:0] b, input logic [1:0] p);
    if (b[19:16] != 4'd0) begin
      return ASCII_QMARK;
    end else begin
      return ASCII_ZERO + {4'd0, b[4*p +: 4]};
    end
  endfunction

  limb_to_bcd #(.WIDTH(WIDTH)) u_bcd (
    .ck    (ck),
    .rst_n (rst_n),
    .load  (load_r),
    .value (snap_r[idx_r]),
    .ready (lb_ready_s),
    .bcd   (lb_bcd_s)
  );

  assign trig_s     = start & ~start_d_r & arm_r;
  assign xfer_s     = out_valid_r & out_ready;
  assign bad_s      = (lb_bcd_s[19:16] != 4'd0);
  assign int_limb_s = (idx_r >= LAST_INT);

  // First digit to show for the converted limb, or skip a zero integer limb.
  always_comb begin
    skip_s = 1'b0;
    pos_s  = 2'd3;
    if (bad_s || !int_limb_s || seen_r) begin
      pos_s = 2'd3;
    end else if (lb_bcd_s[15:12] != 4'd0) begin
      pos_s = 2'd3;
    end else if (lb_bcd_s[11:8] != 4'd0) begin
      pos_s = 2'd2;
    end else if (lb_bcd_s[7:4] != 4'd0) begin
      pos_s = 2'd1;
    end else if ((lb_bcd_s[3:0] != 4'd0) || (idx_r == LAST_INT)) begin
      pos_s = 2'd0;
    end else begin
      pos_s  = 2'd0;
      skip_s = 1'b1;
    end
  end

  // Next-state and next-output logic of the streaming FSM.
  always_comb begin
    state_nx     = state_r;
    snap_nx      = snap_r;
    idx_nx       = idx_r;
    dig_nx       = dig_r;
    load_nx      = 1'b0;
    seen_nx      = seen_r;
    out_valid_nx = out_valid_r;
    out_char_nx  = out_char_r;
    done_nx      = 1'b0;
    error_nx     = error_r;
    case (state_r)
      ST_IDLE: begin
        out_valid_nx = 1'b0;
        if (trig_s) begin
          snap_nx  = in;
          idx_nx   = IDX_TOP;
          error_nx = 1'b0;
          seen_nx  = 1'b0;
          load_nx  = 1'b1;
          state_nx = ST_CONV;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (!load_r && lb_ready_s) begin
          if (skip_s) begin
            idx_nx  = idx_r - IW'(1);
            load_nx = 1'b1;
          end else begin
            state_nx     = ST_EMIT;
            dig_nx       = pos_s;
            out_valid_nx = 1'b1;
            out_char_nx  = digit_char(lb_bcd_s, pos_s);
            seen_nx      = 1'b1;
            error_nx     = error_r | bad_s;
          end
        end else begin
          state_nx = ST_CONV;
        end
      end
      ST_EMIT: begin
        if (xfer_s) begin
          if (dig_r != 2'd0) begin
            dig_nx      = dig_r - 2'd1;
            out_char_nx = digit_char(lb_bcd_s, dig_r - 2'd1);
          end else if (HAS_FRAC && (idx_r == LAST_INT)) begin
            state_nx    = ST_POINT;
            out_char_nx = ASCII_POINT;
          end else if (idx_r == {IW{1'b0}}) begin
            state_nx    = ST_EOL;
            out_char_nx = ASCII_LF;
          end else begin
            out_valid_nx = 1'b0;
            idx_nx       = idx_r - IW'(1);
            load_nx      = 1'b1;
            state_nx     = ST_CONV;
          end
        end else begin
          state_nx = ST_EMIT;
        end
      end
      ST_POINT: begin
        if (xfer_s) begin
          out_valid_nx = 1'b0;
          idx_nx       = idx_r - IW'(1);
          load_nx      = 1'b1;
          state_nx     = ST_CONV;
        end else begin
          state_nx = ST_POINT;
        end
      end
      ST_EOL: begin
        if (xfer_s) begin
          out_valid_nx = 1'b0;
          done_nx      = 1'b1;
          state_nx     = ST_DONE;
        end else begin
          state_nx = ST_EOL;
        end
      end
      ST_DONE: begin
        out_valid_nx = 1'b0;
        state_nx     = ST_IDLE;
      end
      default: begin
        out_valid_nx = 1'b0;
        state_nx     = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      snap_r      <= '0;
      idx_r       <= {IW{1'b0}};
      dig_r       <= 2'd0;
      load_r      <= 1'b0;
      seen_r      <= 1'b0;
      start_d_r   <= 1'b0;
      arm_r       <= 1'b0;
      out_valid_r <= 1'b0;
      out_char_r  <= 8'h00;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r     <= state_nx;
      snap_r      <= snap_nx;
      idx_r       <= idx_nx;
      dig_r       <= dig_nx;
      load_r      <= load_nx;
      seen_r      <= seen_nx;
      start_d_r   <= start;
      // A start level held across reset must drop before it can trigger.
      arm_r       <= arm_r | ~start;
      out_valid_r <= out_valid_nx;
      out_char_r  <= out_char_nx;
      busy_r      <= (state_nx != ST_IDLE);
      done_r      <= done_nx;
      error_r     <= error_nx;
    end
  end

  assign out_valid = out_valid_r;
  assign out_char  = out_char_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;

endmodule

// File: tb/tb_pi_digit_streamer.sv
// Directed self-checking bench for pi_digit_streamer.
module tb_pi_digit_streamer;
  import pi_pkg::*;

  logic       ck;
  logic       rst_n;
  logic       start;
  limbs_t     in_v;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_char;
  logic       busy;
  logic       done;
  logic       error;

  int n_tests;
  int n_fail;

  pi_digit_streamer dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .start     (start),
    .in        (in_v),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_char  (out_char),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start one conversion and collect the stream for a fixed window.
  task automatic run(input string name, input limbs_t v, input bit bp, input int hold,
                     input string exp);
    string      got;
    int         dn;
    logic       stall;
    logic [7:0] pch;
    logic [7:0] gc;
    got   = "";
    dn    = 0;
    stall = 1'b0;
    pch   = 8'h00;
    in_v  = v;
    @(negedge ck);
    start = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge ck);
      if (c == hold) start = 1'b0;
      if (stall) begin
        check({name, "_stall_valid"}, 64'(out_valid), 64'd1);
        check({name, "_stall_char"}, 64'(out_char), 64'(pch));
      end
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) dn++;
      if (out_valid && out_ready) got = $sformatf("%s%c", got, out_char);
      stall = out_valid && !out_ready;
      pch   = out_char;
    end
    out_ready = 1'b1;
    check({name, "_len"}, 64'(got.len()), 64'(exp.len()));
    for (int i = 0; i < exp.len(); i++) begin
      gc = (i < got.len()) ? got[i] : 8'h00;
      check($sformatf("%s_char%0d", name, i), 64'(gc), 64'(exp[i]));
    end
    check({name, "_done_count"}, 64'(dn), 64'd1);
  endtask

  initial begin
    limbs_t pi_v;
    int     waited;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    pi_v      = {16'd0, 16'd3, 16'd1415, 16'd9265};
    in_v      = pi_v;
    repeat (3) @(negedge ck);
    rst_n = 1'b1;
    @(negedge ck);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_char",  64'(out_char),  64'h00);
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_done",  64'(done),      64'd0);
    check("rst_error", 64'(error),     64'd0);

    run("pi", pi_v, 1'b0, 2, "3.14159265\n");
    check("pi_error", 64'(error), 64'd0);

    run("sup_a", {16'd0, 16'd0, 16'd7, 16'd42}, 1'b0, 2, "0.00070042\n");
    run("sup_b", {16'd12, 16'd5, 16'd0, 16'd0}, 1'b0, 2, "120005.00000000\n");

    run("bp", pi_v, 1'b1, 2, "3.14159265\n");

    run("bad", {16'd0, 16'd3, 16'd10000, 16'd1}, 1'b0, 2, "3.????0001\n");
    check("bad_error_held", 64'(error), 64'd1);
    repeat (20) @(negedge ck);
    check("bad_error_still", 64'(error), 64'd1);
    run("clear", pi_v, 1'b0, 2, "3.14159265\n");
    check("clear_error", 64'(error), 64'd0);

    run("hold", pi_v, 1'b0, 100, "3.14159265\n");

    // Reset in the middle of emission, with start left high.
    in_v = pi_v;
    @(negedge ck);
    start  = 1'b1;
    waited = 0;
    while (!out_valid && waited < 300) begin
      @(negedge ck);
      waited++;
    end
    check("mid_reached_emit", 64'(out_valid), 64'd1);
    repeat (2) @(negedge ck);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_char",  64'(out_char),  64'h00);
    check("mid_rst_busy",  64'(busy),      64'd0);
    @(negedge ck);
    rst_n = 1'b1;
    repeat (40) @(negedge ck);
    check("mid_no_retrigger_busy",  64'(busy),      64'd0);
    check("mid_no_retrigger_valid", 64'(out_valid), 64'd0);
    start = 1'b0;
    repeat (2) @(negedge ck);
    run("after_rst", pi_v, 1'b0, 2, "3.14159265\n");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
